// File: rtl/spi_dac_mc.sv
// Multi-channel serial DAC driver: shared divided sclk, per-channel FIFO and frame FSM.
// Build option: DAC_MC_REPEAT_EN makes an idle channel resend its last word every frame slot.
module spi_dac_mc #(
    parameter int NCH     = 2,
    parameter int DW      = 8,
    parameter int DIV     = 2,
    parameter int FIFO_AW = 2,
    parameter int GAP     = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [NCH*DW-1:0] i_data,
    input  logic [NCH-1:0]    i_valid,
    output logic [NCH-1:0]    o_ready,
    output logic              o_sclk,
    output logic [NCH-1:0]    o_dout,
    output logic [NCH-1:0]    o_sync_n,
    output logic [NCH-1:0]    o_busy
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam int CW    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BW    = (DW > 1) ? $clog2(DW) : 1;
    localparam int GW    = (GAP > 1) ? $clog2(GAP) : 1;
    localparam int LW    = FIFO_AW + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAPS  = 2'd2
    } state_t;

    logic [CW-1:0] cnt;
    logic          rise_tick;

    assign rise_tick = (cnt == CW'(DIV - 1)) && !o_sclk;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt    <= '0;
            o_sclk <= 1'b0;
        end else if (cnt == CW'(DIV - 1)) begin
            cnt    <= '0;
            o_sclk <= ~o_sclk;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    for (genvar n = 0; n < NCH; n++) begin : g_ch
        logic [DW-1:0]      mem [DEPTH];
        logic [FIFO_AW-1:0] wptr;
        logic [FIFO_AW-1:0] rptr;
        logic [LW-1:0]      level;
        logic [LW-1:0]      level_nxt;
        logic               ready_q;
        logic               push;
        logic               pop;
        logic               can_start;
        logic               start;
        logic [DW-1:0]      word;

        state_t             state;
        logic [DW-1:0]      shreg;
        logic [BW-1:0]      bitcnt;
        logic [GW-1:0]      gapcnt;
        logic               dout_q;
        logic               sync_q;
        logic               busy_q;

        // The last gap slot also makes the idle decision, so queued
        // frames follow each other with exactly GAP sclk periods between.
        assign can_start = rise_tick &&
                           ((state == IDLE) ||
                            ((state == GAPS) && (gapcnt == '0)));
        assign push      = i_valid[n] & ready_q;
        assign pop       = can_start && (level != '0);

`ifdef DAC_MC_REPEAT_EN
        logic [DW-1:0] last_word;

        assign start = can_start;
        assign word  = pop ? mem[rptr] : last_word;
`else
        assign start = pop;
        assign word  = mem[rptr];
`endif

        always_comb begin
            level_nxt = level;
            unique case ({push, pop})
                2'b10:   level_nxt = level + 1'b1;
                2'b01:   level_nxt = level - 1'b1;
                default: level_nxt = level;
            endcase
        end

        always_ff @(posedge clk) begin
            if (push) begin
                mem[wptr] <= i_data[n*DW +: DW];
            end
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                wptr    <= '0;
                rptr    <= '0;
                level   <= '0;
                ready_q <= 1'b0;
            end else begin
                if (push) wptr <= wptr + 1'b1;
                if (pop)  rptr <= rptr + 1'b1;
                level   <= level_nxt;
                ready_q <= (level_nxt != LW'(DEPTH));
            end
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                state  <= IDLE;
                shreg  <= '0;
                bitcnt <= '0;
                gapcnt <= '0;
                dout_q <= 1'b0;
                sync_q <= 1'b1;
                busy_q <= 1'b0;
`ifdef DAC_MC_REPEAT_EN
                last_word <= '0;
`endif
            end else if (rise_tick) begin
                if (start) begin
                    state  <= SHIFT;
                    shreg  <= word;
                    dout_q <= word[DW-1];
                    sync_q <= 1'b0;
                    bitcnt <= BW'(DW - 1);
                    busy_q <= 1'b1;
`ifdef DAC_MC_REPEAT_EN
                    last_word <= word;
`endif
                end else begin
                    unique case (state)
                        SHIFT: begin
                            if (bitcnt == '0) begin
                                state  <= GAPS;
                                sync_q <= 1'b1;
                                dout_q <= 1'b0;
                                gapcnt <= GW'(GAP - 1);
                            end else begin
                                shreg  <= {shreg[DW-2:0], 1'b0};
                                dout_q <= shreg[DW-2];
                                bitcnt <= bitcnt - 1'b1;
                            end
                        end
                        GAPS: begin
                            if (gapcnt == '0) begin
                                state  <= IDLE;
                                busy_q <= 1'b0;
                            end else begin
                                gapcnt <= gapcnt - 1'b1;
                            end
                        end
                        default: state <= IDLE;
                    endcase
                end
            end
        end

        assign o_ready[n]  = ready_q;
        assign o_dout[n]   = dout_q;
        assign o_sync_n[n] = sync_q;
        assign o_busy[n]   = busy_q;
    end

endmodule

// File: tb/tb_spi_dac_mc.sv
// Randomised bench for spi_dac_mc against a frame-timing reference model.
// The model predicts every output from frame start times derived from the sclk grid.
module tb_spi_dac_mc;

    localparam int NCH     = 2;
    localparam int DW      = 8;
    localparam int DIV     = 2;
    localparam int FIFO_AW = 2;
    localparam int GAP     = 2;
    localparam int DEPTH   = 1 << FIFO_AW;
    localparam int P       = 2 * DIV;
    localparam int FP      = (DW + GAP) * P;
    localparam int MAXF    = 256;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [NCH*DW-1:0] i_data = '0;
    logic [NCH-1:0]    i_valid = '0;
    logic [NCH-1:0]    o_ready;
    logic              o_sclk;
    logic [NCH-1:0]    o_dout;
    logic [NCH-1:0]    o_sync_n;
    logic [NCH-1:0]    o_busy;

    spi_dac_mc #(
        .NCH(NCH), .DW(DW), .DIV(DIV), .FIFO_AW(FIFO_AW), .GAP(GAP)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .i_data(i_data),
        .i_valid(i_valid),
        .o_ready(o_ready),
        .o_sclk(o_sclk),
        .o_dout(o_dout),
        .o_sync_n(o_sync_n),
        .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // edge count since reset release; frame records per channel
    int            e;
    int            nf     [NCH];
    int            fs     [NCH][MAXF];
    logic [DW-1:0] fw     [NCH][MAXF];
    int            lvl    [NCH];
    int            last_s [NCH];
    logic          mrdy   [NCH];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s edge=%0d got=%0h exp=%0h", tag, e, got, exp);
        end
    endtask

    function automatic int next_rise(input int t);
        int r;
        r = t + 1;
        while (r % P != DIV) r++;
        return r;
    endfunction

    task automatic model_reset();
        e = 0;
        for (int c = 0; c < NCH; c++) begin
            nf[c]     = 0;
            lvl[c]    = 0;
            last_s[c] = -4 * FP;
            mrdy[c]   = 1'b0;
        end
    endtask

    task automatic model_edge();
        int s;
        e++;
        for (int c = 0; c < NCH; c++) begin
            if (i_valid[c] && mrdy[c]) begin
                s = next_rise(e);
                if (s < last_s[c] + FP) s = last_s[c] + FP;
                if (nf[c] < MAXF) begin
                    fs[c][nf[c]] = s;
                    fw[c][nf[c]] = i_data[c*DW +: DW];
                    nf[c]++;
                end
                last_s[c] = s;
                lvl[c]++;
            end
            for (int j = 0; j < nf[c]; j++)
                if (fs[c][j] == e) lvl[c]--;
            mrdy[c] = (lvl[c] < DEPTH);
        end
    endtask

    task automatic check_outputs();
        logic xs, xd, xb;
        int   d;
        check("sclk", 32'(o_sclk), 32'((e / DIV) % 2));
        for (int c = 0; c < NCH; c++) begin
            xs = 1'b1;
            xd = 1'b0;
            xb = 1'b0;
            for (int j = 0; j < nf[c]; j++) begin
                d = e - fs[c][j];
                if (d >= 0 && d < FP) begin
                    xb = 1'b1;
                    if (d < DW * P) begin
                        xs = 1'b0;
                        xd = fw[c][j][DW - 1 - d / P];
                    end
                end
            end
            check($sformatf("sync_n%0d", c), 32'(o_sync_n[c]), 32'(xs));
            check($sformatf("dout%0d", c), 32'(o_dout[c]), 32'(xd));
            check($sformatf("busy%0d", c), 32'(o_busy[c]), 32'(xb));
            check($sformatf("ready%0d", c), 32'(o_ready[c]), 32'(mrdy[c]));
        end
    endtask

    task automatic step(input logic [NCH-1:0] v, input logic [NCH*DW-1:0] d);
        i_valid = v;
        i_data  = d;
        @(posedge clk);
        model_edge();
        #1;
        i_valid = '0;
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step('0, '0);
    endtask

    // step until edge t, bounded so a wrong model never hangs the run
    task automatic run_to(input int t);
        int guard;
        guard = 0;
        while (e < t && guard < 500) begin
            step('0, '0);
            guard++;
        end
        check("run_to", 32'(e >= t), 32'd1);
    endtask

    int n0;

    initial begin
        model_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_outputs();
        end
        @(negedge clk);
        reset_n = 1'b1;
        step('0, '0);
        idle(5);

        step(2'b01, {8'h00, 8'hA5});
        idle(60);

        step(2'b10, {8'h55, 8'h00});
        step(2'b10, {8'hAA, 8'h00});
        idle(100);

        n0 = nf[0];
        step(2'b01, {8'h00, 8'h11});
        run_to(fs[0][nf[0]-1] + 1);
        step(2'b01, {8'h00, 8'h22});
        step(2'b01, {8'h00, 8'h33});
        step(2'b01, {8'h00, 8'h44});
        step(2'b01, {8'h00, 8'h55});
        step(2'b01, {8'h00, 8'h66});
        check("accepted", 32'(nf[0] - n0), 32'd5);
        idle(220);

        step(2'b11, {8'hF0, 8'h0F});
        check("align", 32'(fs[1][nf[1]-1]), 32'(fs[0][nf[0]-1]));
        idle(60);

        for (int i = 0; i < 800; i++) begin
            logic [NCH-1:0] v;
            for (int c = 0; c < NCH; c++) v[c] = ($urandom_range(3) == 0);
            step(v, (NCH*DW)'($urandom));
        end
        idle(260);

        step(2'b01, {8'h00, 8'hC3});
        run_to(fs[0][nf[0]-1] + 4 * P + 1);
        check("midframe", 32'(o_sync_n[0]), 32'd0);
        reset_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(negedge clk);
        reset_n = 1'b1;
        idle(120);

        for (int i = 0; i < 300; i++) begin
            logic [NCH-1:0] v;
            for (int c = 0; c < NCH; c++) v[c] = ($urandom_range(1) == 0);
            step(v, (NCH*DW)'($urandom));
        end
        idle(260);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
